layer_stream_tx: RTL and testbench

- Transmit end of the neuron input stream. Captures one parallel vector of M 32-bit IEEE-754 words, such as a previous layer's outputs or the primary input.
- Drives the next layer's shared neuron reset, then presents one word per cycle on a shared x bus in the exact order the neurons consume it.
- Sits between layers: it takes a layer's parallel outputs and feeds the following layer's neurons.
- Signals completion once the downstream MAC pipeline has drained.

---
 rtl/layer_stream_tx.sv | 114 +++++++++++
 tb/tb_layer_stream_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_stream_tx.sv
// Transmit end of a neuron input stream: captures an M-word vector, resets the
// downstream neurons for one cycle, streams the words in order, then waits for the MAC pipeline to drain.
module layer_stream_tx #(
    parameter int M         = 10,
    parameter int DW        = 32,
    parameter int DRAIN_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [M*DW-1:0] in_data,
    output logic            in_ready,
    output logic [DW-1:0]   x_out,
    output logic            nrst_out,
    output logic            busy,
    output logic            done_out
);

    localparam int IW  = (M > 1) ? $clog2(M) : 1;
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [IW-1:0]  IDX_LAST  = IW'(M - 1);
    // DRAIN is left on the edge that completes DRAIN_CYC edges after the last word.
    localparam logic [DCW-1:0] DCNT_LAST = DCW'((DRAIN_CYC > 1) ? DRAIN_CYC - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  buf_q [M];
    logic [IW-1:0]  idx_q;
    logic [IW-1:0]  idx_nxt;
    logic [DCW-1:0] dcnt_q;
    logic [DW-1:0]  x_q;
    logic           nrst_q;
    logic           done_q;
    logic           load;

    assign in_ready = (state_q == IDLE) || (state_q == DONE);
    assign busy     = (state_q == PRIME) || (state_q == STREAM) || (state_q == DRAIN);
    assign load     = in_valid && in_ready;
    assign idx_nxt  = idx_q + IW'(1);

    assign x_out    = x_q;
    assign nrst_out = nrst_q;
    assign done_out = done_q;

    // NOTE: the buffer is pure datapath and is always written before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < M; k++) begin
                buf_q[k] <= in_data[DW*k +: DW];
            end
        end
    end

    // NOTE: every register here uses <= so all of them see the pre-edge state in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            nrst_q  <= 1'b1;
            done_q  <= 1'b0;
            idx_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (in_valid) begin
                        state_q <= PRIME;
                        nrst_q  <= 1'b1;
                        x_q     <= '0;
                        done_q  <= 1'b0;
                    end
                end
                PRIME: begin
                    state_q <= STREAM;
                    idx_q   <= '0;
                    nrst_q  <= 1'b0;
                    x_q     <= buf_q[0];
                end
                STREAM: begin
                    if (idx_q != IDX_LAST) begin
                        idx_q <= idx_nxt;
                        x_q   <= buf_q[idx_nxt];
                    end else begin
                        x_q    <= '0;
                        dcnt_q <= '0;
                        if (DRAIN_CYC == 1) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt_q == DCNT_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q + DCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_stream_tx.sv
// Randomized scoreboard bench for layer_stream_tx: accepted vectors are queued by the
// stimulus, and a negedge monitor checks every streamed word, the drain gap and done timing.
module tb_layer_stream_tx;

    localparam int M         = 10;
    localparam int DW        = 32;
    localparam int DRAIN_CYC = 4;

    typedef logic [M*DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    vec_t          in_data;
    logic          in_ready;
    logic [DW-1:0] x_out;
    logic          nrst_out;
    logic          busy;
    logic          done_out;

    layer_stream_tx #(.M(M), .DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .x_out    (x_out),
        .nrst_out (nrst_out),
        .busy     (busy),
        .done_out (done_out)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;
    int   ready_at = 0;
    vec_t exp_q [$];

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < M; k++) v[DW*k +: DW] = $urandom() | 32'h1;
        return v;
    endfunction

    function automatic vec_t fill_vec(input logic [DW-1:0] w, input logic [DW-1:0] step);
        vec_t v;
        for (int k = 0; k < M; k++) v[DW*k +: DW] = w + step * DW'(k);
        return v;
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one in_valid pulse across the next edge; the model decides whether it is accepted.
    task automatic issue(input vec_t d);
        bit acc;
        acc = (edge_n + 1 >= ready_at);
        check("in_ready_model", in_ready, acc);
        in_valid = 1'b1;
        in_data  = d;
        if (acc) begin
            exp_q.push_back(d);
            ready_at = edge_n + 2 + M + DRAIN_CYC;
        end
        cycle();
        in_valid = 1'b0;
        in_data  = rand_vec();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_x"},     x_out, 0);
        check({tag, "_nrst"},  nrst_out, 1);
        check({tag, "_done"},  done_out, 0);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_busy"},  busy, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (done_out) break;
            cycle();
        end
        check("done_timeout", done_out, 1);
    endtask

    // Monitor: stream start is the 1->0 transition of nrst_out.
    int   mon_pos = -1;
    logic prev_nrst = 1'b1;
    vec_t cur;

    always @(negedge clk) begin
        if (rst) begin
            mon_pos   = -1;
            prev_nrst = 1'b1;
        end else begin
            if (mon_pos < 0 && prev_nrst && !nrst_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_stream", 1, 0);
                end else begin
                    cur     = exp_q.pop_front();
                    mon_pos = 0;
                end
            end
            if (mon_pos >= 0 && mon_pos < M) begin
                check($sformatf("x_word%0d", mon_pos), x_out, cur[DW*mon_pos +: DW]);
                check("stream_nrst", nrst_out, 0);
                check("stream_busy", busy, 1);
                mon_pos++;
            end else if (mon_pos >= M) begin
                check("drain_x", x_out, 0);
                check("drain_nrst", nrst_out, 0);
                if (mon_pos - M + 1 < DRAIN_CYC) begin
                    check("drain_done", done_out, 0);
                    check("drain_busy", busy, 1);
                    mon_pos++;
                end else begin
                    check("done_at_latency", done_out, 1);
                    check("done_ready", in_ready, 1);
                    mon_pos = -1;
                end
            end
            prev_nrst = nrst_out;
        end
    end

    // Behavioural downstream neuron: weights 0.16, bias 0.1, reset while nrst_out=1.
    real acc_r = 0.0;
    int  nsamp = 0;

    always @(negedge clk) begin
        if (nrst_out) begin
            acc_r = 0.0;
            nsamp = 0;
        end else if (x_out != 0) begin
            acc_r = acc_r + f2r(x_out) * 0.16;
            nsamp++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        real  nout;
        vec_t v;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        cycle();
        cycle();
        rst = 1'b0;
        check_idle("reset");

        // Basic stream with distinct words.
        issue(fill_vec(32'h3F80_0000, 32'h1));
        check("prime_nrst", nrst_out, 1);
        check("prime_x", x_out, 0);
        check("prime_busy", busy, 1);
        wait_done();

        // in_valid while busy is dropped.
        issue(fill_vec(32'h4000_0000, 32'h10));
        cycle();
        cycle();
        issue(fill_vec(32'hDEAD_0000, 32'h3));
        wait_done();

        // Mid-stream reset aborts, then a fresh vector starts from word 0.
        issue(rand_vec());
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1;
        exp_q.delete();
        cycle();
        check_idle("midreset");
        rst = 1'b0;
        ready_at = 0;
        issue(rand_vec());
        wait_done();

        // Reload straight from DONE.
        issue(fill_vec(32'h3DCC_CCCD, 32'h0));
        check("reload_done_fall", done_out, 0);
        check("reload_prime_nrst", nrst_out, 1);
        check("reload_prime_x", x_out, 0);
        wait_done();

        // End-to-end into the neuron model.
        issue(fill_vec(32'h3F80_0000, 32'h0));
        wait_done();
        nout = acc_r + 0.1;
        check("neuron_samples", nsamp, M);
        check("neuron_out", ((nout - f2r(32'h3FD9_999A)) < 1e-5) && ((f2r(32'h3FD9_999A) - nout) < 1e-5), 1);

        // Random vectors with stray in_valid pulses.
        for (int n = 0; n < 8; n++) begin
            v = rand_vec();
            issue(v);
            for (int j = 0; j < int'($urandom_range(5, 22)); j++) begin
                if ($urandom_range(0, 3) == 0) issue(rand_vec());
                else cycle();
            end
        end
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && mon_pos < 0 && !busy) break;
            cycle();
        end
        check("all_streams_seen", (exp_q.size() == 0) && (mon_pos < 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
